// File: rtl/sample_shifter_if.sv
// sample_shifter_if: stream, shift-control and status signals of the DAC sample shifter.
// master drives words and shift requests; slave is the shifter itself.
interface sample_shifter_if #(
    parameter int unsigned SAMPLE_W         = 16,
    parameter int unsigned SAMPLES_PER_WORD = 16,
    parameter int unsigned DEPTH_WORDS      = 16
);
    localparam int unsigned WORD_W    = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int unsigned MAX_SHIFT = (DEPTH_WORDS - 1) * SAMPLES_PER_WORD;
    localparam int unsigned SHIFT_W   = $clog2(MAX_SHIFT + 1);

    logic               in_valid;
    logic [WORD_W-1:0]  dac_word_in;
    logic [SHIFT_W-1:0] shift_in;
    logic               shift_load;
    logic               shift_err_clr;
    logic [WORD_W-1:0]  dac_word_out;
    logic               out_valid;
    logic [SHIFT_W-1:0] shift_active;
    logic               shift_pending;
    logic               shift_err;

    modport master (
        output in_valid, dac_word_in, shift_in, shift_load, shift_err_clr,
        input  dac_word_out, out_valid, shift_active, shift_pending, shift_err
    );

    modport slave (
        input  in_valid, dac_word_in, shift_in, shift_load, shift_err_clr,
        output dac_word_out, out_valid, shift_active, shift_pending, shift_err
    );
endinterface

// File: rtl/sample_shifter.sv
// sample_shifter: delays packed DAC words by a run-time programmable number of samples.
// Define SAMPLE_SHIFTER_FLUSH_EN to add a 'flush' port that zeros the history.
module sample_shifter #(
    parameter int unsigned SAMPLE_W         = 16,
    parameter int unsigned SAMPLES_PER_WORD = 16,
    parameter int unsigned DEPTH_WORDS      = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef SAMPLE_SHIFTER_FLUSH_EN
    input  logic flush,
`endif
    sample_shifter_if.slave bus
);
    localparam int unsigned WORD_W    = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int unsigned MAX_SHIFT = (DEPTH_WORDS - 1) * SAMPLES_PER_WORD;
    localparam int unsigned SHIFT_W   = $clog2(MAX_SHIFT + 1);
    localparam int unsigned TOTAL_SMP = DEPTH_WORDS * SAMPLES_PER_WORD;
    localparam int unsigned IDX_W     = $clog2(TOTAL_SMP);

    // History as a flat sample array: index 0 is the oldest sample held.
    logic [TOTAL_SMP-1:0][SAMPLE_W-1:0]        hist_q, hist_d, hist_base;
    logic [SAMPLES_PER_WORD-1:0][SAMPLE_W-1:0] word_in, word_q, word_d;
    logic                                      out_valid_q;
    logic [SHIFT_W-1:0]                        active_q, active_d;
    logic [SHIFT_W-1:0]                        pending_q, pending_d;
    logic                                      pending_flag_q, pending_flag_d;
    logic                                      err_q, err_d;
    logic                                      over_c;
    logic [SHIFT_W-1:0]                        load_val_c;
    logic [IDX_W-1:0]                          base_c;

    assign word_in = bus.dac_word_in;

    // Next-state: shift handshake, history update and window selection.
    always_comb begin
        hist_d         = hist_q;
        word_d         = word_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        err_d          = err_q;
        hist_base      = hist_q;
        base_c         = '0;

        over_c     = bus.shift_in > SHIFT_W'(MAX_SHIFT);
        load_val_c = over_c ? SHIFT_W'(MAX_SHIFT) : bus.shift_in;

        if (bus.shift_load) begin
            pending_d      = load_val_c;
            pending_flag_d = 1'b1;
        end

        if (bus.shift_load && over_c) begin
            err_d = 1'b1;
        end else if (bus.shift_err_clr) begin
            err_d = 1'b0;
        end

`ifdef SAMPLE_SHIFTER_FLUSH_EN
        if (flush) begin
            hist_base = '0;
        end
`endif
        hist_d = hist_base;

        if (bus.in_valid) begin
            hist_d = {word_in, hist_base[TOTAL_SMP-1:SAMPLES_PER_WORD]};
            if (pending_flag_d) begin
                active_d       = pending_d;
                pending_flag_d = 1'b0;
            end
            // Output sample j is history sample (MAX_SHIFT - S + j).
            base_c = IDX_W'(MAX_SHIFT) - IDX_W'(active_d);
            for (int unsigned j = 0; j < SAMPLES_PER_WORD; j++) begin
                word_d[j] = hist_d[base_c + IDX_W'(j)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q         <= '0;
            word_q         <= '0;
            out_valid_q    <= 1'b0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_flag_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            hist_q         <= hist_d;
            word_q         <= word_d;
            out_valid_q    <= bus.in_valid;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_flag_q <= pending_flag_d;
            err_q          <= err_d;
        end
    end

    assign bus.dac_word_out  = WORD_W'(word_q);
    assign bus.out_valid     = out_valid_q;
    assign bus.shift_active  = active_q;
    assign bus.shift_pending = pending_flag_q;
    assign bus.shift_err     = err_q;
endmodule

// File: tb/tb_sample_shifter.sv
// tb_sample_shifter: directed scenarios plus random stream, checked every cycle against a
// sample-stream model (output sample j of word n = stream[n*SPW + j - S], 0 if negative).
module tb_sample_shifter;
    localparam int unsigned SW   = 16;
    localparam int unsigned SPW  = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned WW   = SW * SPW;
    localparam int unsigned MAXS = (DW - 1) * SPW;
    localparam int unsigned SHW  = $clog2(MAXS + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_shifter_if #(.SAMPLE_W(SW), .SAMPLES_PER_WORD(SPW), .DEPTH_WORDS(DW)) bus ();

`ifdef SAMPLE_SHIFTER_FLUSH_EN
    logic flush = 1'b0;
`endif

    sample_shifter #(.SAMPLE_W(SW), .SAMPLES_PER_WORD(SPW), .DEPTH_WORDS(DW)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SAMPLE_SHIFTER_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    // Model state
    logic [SW-1:0]  stream[$];
    logic [WW-1:0]  e_word;
    logic           e_valid;
    logic [SHW-1:0] e_active;
    logic [SHW-1:0] m_pval;
    logic           e_pending;
    logic           e_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned gw = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] mkword(input int unsigned w);
        logic [WW-1:0] r;
        for (int j = 0; j < SPW; j++) r[j*SW +: SW] = SW'(w * SPW + 32'(j) + 1);
        return r;
    endfunction

    function automatic logic [WW-1:0] rndword();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW-1:0] smp(input logic [WW-1:0] w, input int j);
        return w[j*SW +: SW];
    endfunction

    task automatic model_step();
        int base;
        int idx;
        if (!rst) begin
            stream.delete();
            e_word = '0; e_valid = 1'b0; e_active = '0;
            m_pval = '0; e_pending = 1'b0; e_err = 1'b0;
            return;
        end
        if (bus.shift_load) begin
            m_pval    = (int'(bus.shift_in) > int'(MAXS)) ? SHW'(MAXS) : bus.shift_in;
            e_pending = 1'b1;
        end
        if (bus.shift_load && int'(bus.shift_in) > int'(MAXS)) e_err = 1'b1;
        else if (bus.shift_err_clr) e_err = 1'b0;
        e_valid = bus.in_valid;
        if (bus.in_valid) begin
            if (e_pending) begin
                e_active  = m_pval;
                e_pending = 1'b0;
            end
            for (int j = 0; j < SPW; j++) stream.push_back(bus.dac_word_in[j*SW +: SW]);
            base = stream.size() - SPW;
            for (int j = 0; j < SPW; j++) begin
                idx = base + j - int'(e_active);
                e_word[j*SW +: SW] = (idx < 0) ? SW'(0) : stream[idx];
            end
        end
    endtask

    // One clock: model follows the sampled inputs, then every output is compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("dac_word_out",  bus.dac_word_out, e_word);
        check("out_valid",     WW'(bus.out_valid), WW'(e_valid));
        check("shift_active",  WW'(bus.shift_active), WW'(e_active));
        check("shift_pending", WW'(bus.shift_pending), WW'(e_pending));
        check("shift_err",     WW'(bus.shift_err), WW'(e_err));
    endtask

    task automatic step(input logic v);
        bus.in_valid    = v;
        bus.dac_word_in = v ? mkword(gw) : rndword();
        if (v) gw++;
        tick();
        bus.shift_load    = 1'b0;
        bus.shift_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.dac_word_in = rndword();
        tick();
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        gw = 0;
    endtask

    task automatic load(input int unsigned s);
        bus.shift_in   = SHW'(s);
        bus.shift_load = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.dac_word_in = '0;
        bus.shift_in = '0;
        bus.shift_load = 1'b0;
        bus.shift_err_clr = 1'b0;

        // 1: shift 0 passes words through with one cycle latency
        do_reset();
        check("rst_word", bus.dac_word_out, '0);
        check("rst_err",  WW'(bus.shift_err), '0);
        load(0); step(1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check("t1_word", bus.dac_word_out, mkword(32'(k)));
        end
        step(1'b0);

        // 2: shift of one sample
        do_reset();
        load(1); step(1'b0);
        step(1'b1);
        check("t2_s0",  WW'(smp(bus.dac_word_out, 0)), WW'(0));
        check("t2_s1",  WW'(smp(bus.dac_word_out, 1)), WW'(1));
        check("t2_s15", WW'(smp(bus.dac_word_out, 15)), WW'(15));
        step(1'b1);
        check("t2_w1s0",  WW'(smp(bus.dac_word_out, 0)), WW'(16));
        check("t2_w1s15", WW'(smp(bus.dac_word_out, 15)), WW'(31));
        check("t2_model", WW'(smp(e_word, 15)), WW'(31));
        step(1'b1);

        // 3: maximum shift returns the oldest stored word
        do_reset();
        load(MAXS); step(1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1);
            if (k == 14) check("t3_w14", bus.dac_word_out, '0);
            if (k == 15) check("t3_w15", bus.dac_word_out, mkword(0));
        end

        // 4: out-of-range shift clamps and sets a sticky error
        do_reset();
        load(250); step(1'b1);
        check("t4_active", WW'(bus.shift_active), WW'(MAXS));
        check("t4_err",    WW'(bus.shift_err), WW'(1));
        step(1'b0); step(1'b1);
        check("t4_sticky", WW'(bus.shift_err), WW'(1));
        bus.shift_err_clr = 1'b1; step(1'b0);
        check("t4_clr", WW'(bus.shift_err), WW'(0));
        load(250); bus.shift_err_clr = 1'b1; step(1'b0);
        check("t4_setwins", WW'(bus.shift_err), WW'(1));

        // 5: shift loaded during a stall applies to the next accepted word
        do_reset();
        load(0); step(1'b0);
        for (int k = 0; k < 3; k++) step(1'b1);
        load(17); step(1'b0);
        check("t5_pend", WW'(bus.shift_pending), WW'(1));
        check("t5_hold", bus.dac_word_out, mkword(2));
        step(1'b0);
        step(1'b1);
        check("t5_applied", WW'(bus.shift_active), WW'(17));
        check("t5_s0",      WW'(smp(bus.dac_word_out, 0)), WW'(32));
        check("t5_nopend",  WW'(bus.shift_pending), WW'(0));

        // 6: mid-stream reset wins over valid; old samples read back as zero
        for (int k = 0; k < 3; k++) step(1'b1);
        rst = 1'b0; step(1'b1);
        check("t6_word",   bus.dac_word_out, '0);
        check("t6_active", WW'(bus.shift_active), WW'(0));
        rst = 1'b1; gw = 0;
        load(20); step(1'b1);
        check("t6_s0",  WW'(smp(bus.dac_word_out, 0)), WW'(0));
        check("t6_s15", WW'(smp(bus.dac_word_out, 15)), WW'(0));
        step(1'b1);
        check("t6_w1s4", WW'(smp(bus.dac_word_out, 4)), WW'(1));
        step(1'b1);

        // Random stream with stalls, loads, clears and occasional resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(0, 149) != 0);
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.dac_word_in   = rndword();
            bus.shift_load    = ($urandom_range(0, 7) == 0);
            bus.shift_in      = SHW'($urandom_range(0, (1 << SHW) - 1));
            bus.shift_err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_shifter.md
Name: sample_shifter

Overview:
- Parametrised successor to the DAC sample shifter. It delays a stream of packed DAC words by a run-time programmable number of samples, from 0 up to (DEPTH_WORDS-1)*SAMPLES_PER_WORD.
- Sits between the pulse/waveform generator and the RFSoC DAC AXI-stream interface.
- Adds the following over the previous generation:
  - generic sample/word/depth sizing
  - input valid with stall support
  - a safe shift-update handshake applied on a word boundary
  - clamping of out-of-range shifts, with a sticky error flag

Parameters:
- SAMPLE_W, 16, bits per DAC sample.
- SAMPLES_PER_WORD, 16, samples packed per DAC word. Sample 0 is in bits [SAMPLE_W-1:0] and is the earliest sample in time.
- DEPTH_WORDS, 16, words of history held, including the current word. Must be >= 2.
- MAX_SHIFT, (DEPTH_WORDS-1)*SAMPLES_PER_WORD, derived, largest legal shift in samples.
- SHIFT_W, $clog2(MAX_SHIFT+1), derived, width of shift values.
- WORD_W, SAMPLE_W*SAMPLES_PER_WORD, derived, bits per DAC word.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  dac_word_in is accepted this cycle.
- dac_word_in  in  WORD_W  input DAC word.
- shift_in  in  SHIFT_W  requested shift, in samples.
- shift_load  in  1  one-cycle strobe that captures shift_in as the pending shift.
- shift_err_clr  in  1  clears shift_err.
- dac_word_out  out  WORD_W  shifted DAC word (registered).
- out_valid  out  1  dac_word_out updated this cycle.
- shift_active  out  SHIFT_W  shift currently applied to the output.
- shift_pending  out  1  a loaded shift is waiting for the next accepted word.
- shift_err  out  1  sticky flag: a loaded shift exceeded MAX_SHIFT.

Behaviour:
- Reset is synchronous on rst==0 at the clk edge, and takes priority over every other input, including mid-stream. All of the following clear to 0:
  - history register (DEPTH_WORDS*WORD_W bits)
  - dac_word_out, out_valid
  - shift_active, the pending register, shift_pending
  - shift_err
- History:
  - On in_valid=1, the history shifts by one word and dac_word_in enters as the newest word.
  - On in_valid=0, history holds.
  - Samples from before reset read as zero.
- Output sample j of the word produced for accepted input word n equals stream sample (n*SAMPLES_PER_WORD + j - S), where S is the applied shift. A negative stream index gives 0.
- Latency:
  - dac_word_out and out_valid are registered 1 cycle after the accepting edge.
  - out_valid equals in_valid delayed by 1 cycle.
  - During stalls, dac_word_out holds its last value and out_valid=0.
- Shift update:
  - shift_load=1 captures min(shift_in, MAX_SHIFT) into the pending register and sets shift_pending.
  - If shift_in > MAX_SHIFT, shift_err is set. It stays set until shift_err_clr=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- Apply point:
  - On the first in_valid=1 cycle with shift_pending=1, the pending value becomes shift_active and shift_pending clears.
  - That same word is computed with the new shift.
  - If shift_load and in_valid are in the same cycle, the newly loaded value applies to that word.
  - A second shift_load before the apply point overwrites the pending value; only the last one is applied.
- Window selection:
  - The bit offset equals (DEPTH_WORDS-1)*WORD_W - S*SAMPLE_W, measured from the oldest word.
  - A purely indexed part-select is used; no multipliers.
  - S=0 gives the current input word; S=MAX_SHIFT gives the oldest stored word exactly.
- No state machine beyond the pending and apply flag. The datapath is one register stage.

Optional Feature:
- Macro: SAMPLE_SHIFTER_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 zeros the entire history register at the clock edge; shift settings are unaffected.
  - If in_valid=1 in the same cycle, the history becomes {zeros, dac_word_in}. The output for that word uses the zeroed history, so only samples from dac_word_in can be non-zero.
  - flush has lower priority than reset.
- When undefined: no flush port; history is cleared only by reset.

Test Plan:
- Conditions for all tests: SAMPLE_W=16, SAMPLES_PER_WORD=16, DEPTH_WORDS=16. Input sample value = global sample index + 1.
1. Reset; shift_load shift_in=0, then stream 4 words -> each dac_word_out equals its input word 1 cycle later; out_valid pulses mirror in_valid; shift_active=0.
2. shift_in=1 before the first word, then stream 3 words -> first output has sample0=0 and samples1..15=1..15; second output has sample0=16 and sample15=31.
3. shift_in=240, then stream 20 words -> outputs 0..14 are all zero; output 15 equals input word 0 (values 1..16).
4. shift_in=250 -> shift_active=240 after the next word, shift_err=1 and remains set; shift_err_clr pulse -> 0. Same-cycle load of 250 and clr -> shift_err=1.
5. Stream with in_valid gaps; shift_load 17 during a gap -> shift_pending=1 and the output holds through the gap; the first word after the gap uses shift 17 and shift_pending clears.
6. Mid-stream rst=0 for 1 cycle with in_valid=1 -> next cycle all outputs are 0. Resume the stream -> delayed samples reaching back before reset read 0.
